// File: rtl/div_8_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Handshake: start is honoured only when busy is low; done pulses for one cycle with results valid.
module div_8_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int PW    = DIVISOR_W + 1;
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [PW-1:0]         part_q, part_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [PW:0]           shifted;
    logic                  take;
    logic [PW-1:0]         trial;
    logic [PW-1:0]         step_part;

    // dvd_q doubles as the quotient register: dividend bits leave at the top,
    // quotient bits enter at the bottom, so after N steps it holds the quotient.
    always_comb begin
        shifted   = {part_q, dvd_q[DIVIDEND_W-1]};
        take      = (shifted >= {2'b00, dvs_q});
        trial     = PW'(shifted - {2'b00, dvs_q});
        step_part = take ? trial : shifted[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (divisor == '0) ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        part_d = part_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d = '1;
                        rem_d  = '0;
                        dbz_d  = 1'b1;
                    end else begin
                        dvd_d  = dividend;
                        dvs_d  = divisor;
                        part_d = '0;
                        cnt_d  = CNT_W'(DIVIDEND_W - 1);
                        dbz_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                dvd_d  = {dvd_q[DIVIDEND_W-2:0], take};
                part_d = step_part;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quot_d = {dvd_q[DIVIDEND_W-2:0], take};
                    rem_d  = step_part[DIVISOR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_div_8_seq.sv
// Directed and randomised checks for div_8_seq; inputs driven and outputs sampled on the falling edge.
module tb_div_8_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q[$];

    div_8_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic pulse_start(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts cycles from the start cycle to the cycle showing done (bounded).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc;
        pulse_start(16'd300, 8'd7);
        wait_done(lat, bc);
        checks++; if (lat != 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
        checks++; if (bc != 17) begin errors++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
        checks++; if (quotient !== 16'd42) begin errors++; $display("FAIL basic_quotient got %0d want 42", quotient); end
        checks++; if (remainder !== 8'd6) begin errors++; $display("FAIL basic_remainder got %0d want 6", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %0b want 0", div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b want 0", busy); end
    endtask

    task automatic test_values;
        logic [15:0] ta[3] = '{16'd65535, 16'd5, 16'd65535};
        logic [7:0]  tb[3] = '{8'd255, 8'd9, 8'd1};
        logic [15:0] tq[3] = '{16'd257, 16'd0, 16'd65535};
        logic [7:0]  tr[3] = '{8'd0, 8'd5, 8'd0};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            pulse_start(ta[i], tb[i]);
            wait_done(lat, bc);
            checks++; if (quotient !== tq[i]) begin errors++; $display("FAIL values_quotient[%0d] got %0d want %0d", i, quotient, tq[i]); end
            checks++; if (remainder !== tr[i]) begin errors++; $display("FAIL values_remainder[%0d] got %0d want %0d", i, remainder, tr[i]); end
        end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        pulse_start(16'd100, 8'd0);
        wait_done(lat, bc);
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_quotient got %h want ffff", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL dz_remainder got %0d want 0", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", div_by_zero); end
        pulse_start(16'd10, 8'd3);
        wait_done(lat, bc);
        checks++; if (quotient !== 16'd3) begin errors++; $display("FAIL dz_next_quotient got %0d want 3", quotient); end
        checks++; if (remainder !== 8'd1) begin errors++; $display("FAIL dz_next_remainder got %0d want 1", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag got %0b want 0", div_by_zero); end
    endtask

    task automatic test_start_ignored;
        int lat, bc, pulses;
        pulse_start(16'd300, 8'd7);
        repeat (3) @(negedge clk);
        dividend = 16'd1000; divisor = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        checks++; if (quotient !== 16'd42) begin errors++; $display("FAIL ign_quotient got %0d want 42", quotient); end
        checks++; if (remainder !== 8'd6) begin errors++; $display("FAIL ign_remainder got %0d want 6", remainder); end
        dividend = 16'd1000; divisor = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start_busy got %0b want 0", busy); end
        pulses = 0;
        repeat (25) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL ign_extra_done got %0d want 0", pulses); end
        checks++; if (quotient !== 16'd42) begin errors++; $display("FAIL ign_hold_quotient got %0d want 42", quotient); end
        checks++; if (remainder !== 8'd6) begin errors++; $display("FAIL ign_hold_remainder got %0d want 6", remainder); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, pulses;
        pulse_start(16'd300, 8'd7);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %0b want 0", done); end
        checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL rmid_quotient got %0d want 0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL rmid_remainder got %0d want 0", remainder); end
        pulses = 0;
        repeat (30) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_activity got %0d want 0", pulses); end
        pulse_start(16'd49, 8'd7);
        wait_done(lat, bc);
        checks++; if (quotient !== 16'd7) begin errors++; $display("FAIL rmid_fresh_quotient got %0d want 7", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL rmid_fresh_remainder got %0d want 0", remainder); end
    endtask

    task automatic test_random;
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        ez;
        logic [24:0] exp;
        int lat, bc;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(0, 255));
            if (b == 8'd0) begin
                eq = 16'hFFFF; er = 8'd0; ez = 1'b1;
            end else begin
                eq = a / {8'd0, b}; er = 8'(a % {8'd0, b}); ez = 1'b0;
            end
            exp_q.push_back({ez, er, eq});
            pulse_start(a, b);
            wait_done(lat, bc);
            exp = exp_q.pop_front();
            checks++;
            if (done !== 1'b1 || {div_by_zero, remainder, quotient} !== exp ||
                (b != 8'd0 && ((32'(quotient) * 32'(b) + 32'(remainder)) != 32'(a) || remainder >= b))) begin
                errors++;
                $display("FAIL rand[%0d] %0d/%0d got q=%0d r=%0d z=%0b want q=%0d r=%0d z=%0b",
                         i, a, b, quotient, remainder, div_by_zero, exp[15:0], exp[23:16], exp[24]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_div_zero;
        test_start_ignored;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
